regfile_wrsched: RTL and testbench

Write-port scheduler and scoreboard for the 16x16-bit register file. It arbitrates two writeback requesters (ALU result, memory load) onto the single register-file write port (`wen`/`selR`/`bus`) using round-robin priority and valid/ready handshakes. It also tracks a 16-bit busy mask of registers reserved by the issue stage, so decode can detect read-after-write hazards. It sits between the execute/memory stages and the register file's write inputs.

---
 rtl/regfile_wrsched.sv | 64 ++++++
 tb/tb_regfile_wrsched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wrsched.sv
// Write-port scheduler and busy-mask scoreboard for the 16x16 register file.
// Round-robin arbitration of ALU and load writebacks onto one registered write port.
module regfile_wrsched (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        v0,
  input  logic [3:0]  d0,
  input  logic [15:0] x0,
  output logic        r0,
  input  logic        v1,
  input  logic [3:0]  d1,
  input  logic [15:0] x1,
  output logic        r1,
  input  logic        rsv_v,
  input  logic [3:0]  rsv_sel,
  output logic        rsv_r,
  output logic        wen,
  output logic [3:0]  selR,
  output logic [15:0] bus,
  output logic [15:0] busy
);

  logic        last;       // index of the most recently granted requester
  logic        xfer;
  logic [15:0] busy_next;

  // last==1 means requester 1 won the previous transfer, so requester 0 wins a tie.
  assign r0   = ~rst & ~hold & v0 & (~v1 | last);
  assign r1   = ~rst & ~hold & v1 & (~v0 | ~last);
  assign xfer = r0 | r1;

  // The retiring write frees its register in the same cycle it may be re-reserved.
  assign rsv_r = ~rst & (~busy[rsv_sel] | (wen & (selR == rsv_sel)));

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wen)
      busy_next[selR] = 1'b0;
    if (rsv_v && rsv_r)
      busy_next[rsv_sel] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen  <= 1'b0;
      selR <= 4'd0;
      bus  <= 16'h0000;
      busy <= 16'h0000;
      last <= 1'b1;
    end else begin
      wen  <= xfer;
      busy <= busy_next;
      if (xfer) begin
        last <= r1;
        selR <= r1 ? d1 : d0;
        bus  <= r1 ? x1 : x0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wrsched.sv
// Directed self-checking bench for regfile_wrsched: reset, round-robin contention,
// scoreboard set/clear, re-reservation, hold and reset during a pending write.
module tb_regfile_wrsched;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        v0;
  logic [3:0]  d0;
  logic [15:0] x0;
  logic        r0;
  logic        v1;
  logic [3:0]  d1;
  logic [15:0] x1;
  logic        r1;
  logic        rsv_v;
  logic [3:0]  rsv_sel;
  logic        rsv_r;
  logic        wen;
  logic [3:0]  selR;
  logic [15:0] bus;
  logic [15:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wrsched dut (
    .clk(clk), .rst(rst), .hold(hold),
    .v0(v0), .d0(d0), .x0(x0), .r0(r0),
    .v1(v1), .d1(d1), .x1(x1), .r1(r1),
    .rsv_v(rsv_v), .rsv_sel(rsv_sel), .rsv_r(rsv_r),
    .wen(wen), .selR(selR), .bus(bus), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    v0 = 1'b1; d0 = 4'd3; x0 = 16'hAAAA;
    v1 = 1'b1; d1 = 4'd5; x1 = 16'h5555;
    rsv_v = 1'b1; rsv_sel = 4'd2;

    // Reset for two cycles with everything requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_r0", r0, 0);
      check("rst_r1", r1, 0);
      check("rst_rsv_r", rsv_r, 0);
      check("rst_wen", wen, 0);
      check("rst_busy", busy, 16'h0000);
    end
    check("rst_selR", selR, 0);
    check("rst_bus", bus, 16'h0000);

    // Contention: grants alternate 0,1,0,1 starting with requester 0
    rst = 1'b0; rsv_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_r0", r0, (k % 2 == 0));
      check("cont_r1", r1, (k % 2 == 1));
      tick();
      check("cont_wen", wen, 1);
      check("cont_selR", selR, (k % 2 == 0) ? 3 : 5);
      check("cont_bus", bus, (k % 2 == 0) ? 16'hAAAA : 16'h5555);
    end
    v0 = 1'b0; v1 = 1'b0;
    check("cont_busy_unres", busy, 16'h0000);
    tick();
    check("idle_wen", wen, 0);
    check("idle_selR_hold", selR, 5);
    check("idle_bus_hold", bus, 16'h5555);

    // Scoreboard: reserve R7
    rsv_v = 1'b1; rsv_sel = 4'd7;
    #1 check("rsv7_accept", rsv_r, 1);
    tick();
    check("rsv7_busy", busy, 16'h0080);
    #1 check("rsv7_reject", rsv_r, 0);
    rsv_v = 1'b0;
    tick();
    tick();
    check("rsv7_busy_wait", busy, 16'h0080);
    v0 = 1'b1; d0 = 4'd7; x0 = 16'h1234;
    #1 check("w7_r0", r0, 1);
    tick();
    v0 = 1'b0;
    check("w7_wen", wen, 1);
    check("w7_selR", selR, 7);
    check("w7_bus", bus, 16'h1234);
    check("w7_busy_still", busy, 16'h0080);
    // Retiring cycle: re-reservation allowed, bit stays set
    rsv_v = 1'b1; rsv_sel = 4'd7;
    #1 check("retire_rsv_r", rsv_r, 1);
    tick();
    rsv_v = 1'b0;
    check("retire_busy", busy, 16'h0080);
    check("retire_wen", wen, 0);

    // Load retires R7 with no new reservation: bit clears a cycle later
    v1 = 1'b1; d1 = 4'd7; x1 = 16'hBEEF;
    #1 check("ld7_r1", r1, 1);
    tick();
    v1 = 1'b0;
    check("ld7_bus", bus, 16'hBEEF);
    check("ld7_busy_pending", busy, 16'h0080);
    tick();
    check("ld7_busy_clear", busy, 16'h0000);

    // Hold: write registered just before hold still pulses
    v0 = 1'b1; d0 = 4'd1; x0 = 16'h0101;
    #1 check("pre_hold_r0", r0, 1);
    tick();
    v0 = 1'b0; v1 = 1'b1; d1 = 4'd9; x1 = 16'h9999; hold = 1'b1;
    rsv_v = 1'b1; rsv_sel = 4'd9;
    #1;
    check("hold_wen_pulse", wen, 1);
    check("hold_selR", selR, 1);
    check("hold_rsv_ok", rsv_r, 1);
    for (int i = 0; i < 3; i++) begin
      check("hold_r1", r1, 0);
      tick();
      rsv_v = 1'b0;
      check("hold_wen", wen, 0);
      #1;
    end
    check("hold_busy9", busy, 16'h0200);
    hold = 1'b0;
    #1 check("unhold_r1", r1, 1);
    tick();
    v1 = 1'b0;
    check("unhold_wen", wen, 1);
    check("unhold_selR", selR, 9);
    check("unhold_bus", bus, 16'h9999);
    tick();
    check("unhold_busy", busy, 16'h0000);

    // Reset while a write to a reserved register is pending
    rsv_v = 1'b1; rsv_sel = 4'd4;
    tick();
    rsv_v = 1'b0;
    check("pre_rst_busy", busy, 16'h0010);
    v0 = 1'b1; d0 = 4'd4; x0 = 16'h4444;
    #1 check("pre_rst_r0", r0, 1);
    tick();
    check("pre_rst_wen", wen, 1);
    rst = 1'b1;
    #1 check("mid_rst_r0", r0, 0);
    tick();
    check("mid_rst_wen", wen, 0);
    check("mid_rst_busy", busy, 16'h0000);
    check("mid_rst_selR", selR, 0);
    rst = 1'b0; v1 = 1'b1; d1 = 4'd5; x1 = 16'h5555;
    #1;
    check("post_rst_r0", r0, 1);
    check("post_rst_r1", r1, 0);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    check("post_rst_selR", selR, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
